serial_add_sub_n: RTL

Parametrised bit-serial adder/subtractor. It loads two N-bit operands in parallel and processes one bit per enabled clock, LSB first, through a single full-adder and a carry flip-flop. It returns the N-bit result, carry/borrow and signed overflow under a start/busy/done handshake. It is the N-bit, two-mode, flow-controlled generation of the team's 4-bit shift-register serial adder, and it serves as the arithmetic datapath for multi-cycle ALU experiments.

---
 rtl/serial_add_sub_n.sv | 135 +++++++++++++
 1 files changed

// File: rtl/serial_add_sub_n.sv
// serial_add_sub_n: bit-serial N-bit adder/subtractor.
// Operands are loaded in parallel. One full-adder plus a carry flip-flop then
// process one bit per enabled clock, LSB first. The result fills the A shift
// register from the MSB end.
//
// Handshake: start is sampled only in IDLE. A start accepted at a clock edge
// captures a_in/b_in/sub and moves the block to RUN. busy is high for the
// whole of RUN, including stall cycles with en=0. done is high for exactly one
// cycle (the DONE state), and sum/carry_out/overflow are valid from that cycle
// until the next accepted start. start is ignored in RUN and in DONE.
module serial_add_sub_n #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic         en,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         carry_out,
    output logic         overflow
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [N-1:0]   a_q;
    logic [N-1:0]   b_q;
    logic           carry_q;
    logic           mode_q;
    logic [CW-1:0]  cnt_q;

    logic           accept;
    logic           step;
    logic           last_bit;
    logic           b_eff;
    logic           s_bit;
    logic           c_bit;

    // Single full-adder stage; subtraction inverts B and injects the +1 via the initial carry.
    assign b_eff    = b_q[0] ^ mode_q;
    assign s_bit    = a_q[0] ^ b_eff ^ carry_q;
    assign c_bit    = (a_q[0] & b_eff) | (a_q[0] & carry_q) | (b_eff & carry_q);
    assign last_bit = step && (cnt_q == LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (en) begin
                    step = 1'b1;
                    if (cnt_q == LAST) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand shift registers, carry, mode and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            a_q     <= a_in;
            b_q     <= b_in;
            mode_q  <= sub;
            carry_q <= sub;
            cnt_q   <= '0;
        end else if (step) begin
            a_q     <= {s_bit, a_q[N-1:1]};
            b_q     <= {1'b0, b_q[N-1:1]};
            carry_q <= c_bit;
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    // Result registers load only on the final bit and hold between operations.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (last_bit) begin
            sum       <= {s_bit, a_q[N-1:1]};
            carry_out <= c_bit;
            overflow  <= carry_q ^ c_bit;
        end
    end

endmodule
